// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, the one-hot
// step-bus constants and the instruction-register field layout.
package instr_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      LOAD_IR,
      DECODE,
      RD_A,
      RD_B,
      EXEC,
      HALT,
      ERR
   } state_t;

   localparam logic [5:0] SEQ_NONE = 6'b000000;
   localparam logic [5:0] SEQ_0    = 6'b000001;
   localparam logic [5:0] SEQ_1    = 6'b000010;
   localparam logic [5:0] SEQ_2    = 6'b000100;
   localparam logic [5:0] SEQ_3    = 6'b001000;
   localparam logic [5:0] SEQ_4    = 6'b010000;
   localparam logic [5:0] SEQ_5    = 6'b100000;

   // IR layout: [7]=compute, [6:4]=op, [3:2]=RA, [1:0]=RB
   localparam int         IR_COMPUTE_BIT = 7;
   localparam logic [3:0] HLT_OP         = 4'b0111;

   // The halt opcode is recognised on the top nibble (compute bit clear plus op field)
   function automatic logic is_halt(input logic [7:0] ir_val);
      return ir_val[7:4] == HLT_OP;
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Opcode fetch handshake between the sequencer and instruction memory.
// The sequencer raises mem_req; memory answers with mem_ack and the opcode byte.
interface instr_sequencer_if;

   logic       mem_req;
   logic       mem_ack;
   logic [7:0] mem_data;

   modport master (
      output mem_req,
      input  mem_ack,
      input  mem_data
   );

   modport slave (
      input  mem_req,
      output mem_ack,
      output mem_data
   );

endinterface

// File: rtl/instr_sequencer_fetch_watchdog.sv
// Fetch watchdog: counts FETCH cycles that pass without an acknowledge and
// flags expiry on the last permitted cycle, so the FSM can fall into ERR.
// An acknowledge in the expiry cycle suppresses the flag.
module fetch_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic ack,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] count;

   // Count unacknowledged fetch cycles; any ack or leaving FETCH starts over
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!active || ack) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // count holds the unacked cycles already seen, so this cycle is number count+1
   always_comb begin
      expire = active && !ack && (count == CW'(TIMEOUT - 1));
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 8-bit core.
// Optional feature: define INSTR_SEQ_STEP_EN to add the single-step port;
// every instruction then needs a fresh step pulse (with run=1) to start.
module instr_sequencer
   import instr_seq_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             stall,
`ifdef INSTR_SEQ_STEP_EN
   input  logic             step,
`endif
   instr_sequencer_if.master mem,
   output logic [7:0]       ir,
   output logic [5:0]       seq,
   output logic             pc_inc,
   output logic             ora,
   output logic             orb,
   output logic             irb,
   output logic             halted,
   output logic             bus_err,
   output logic [CNT_W-1:0] instr_cnt
);

   state_t state;
   state_t state_next;
   logic   ir_load;
   logic   retire;
   logic   expire;
   logic   go;
   state_t retire_to;

   fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .active (state == FETCH),
      .ack    (mem.mem_ack),
      .expire (expire)
   );

`ifdef INSTR_SEQ_STEP_EN
   logic step_q;

   // Remember last step level so a held step only counts once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= 1'b0;
      end else begin
         step_q <= step;
      end
   end

   assign go        = step && !step_q;
   assign retire_to = IDLE;
`else
   assign go        = 1'b1;
   assign retire_to = run ? FETCH : IDLE;
`endif

   // State, instruction register and retired-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ir        <= 8'h00;
         instr_cnt <= '0;
      end else begin
         state <= state_next;
         if (ir_load) begin
            ir <= mem.mem_data;
         end
         if (retire) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
         end
      end
   end

   // Next-state logic; stall freezes the DECODE..EXEC walk, ack beats the watchdog
   always_comb begin
      state_next = state;
      ir_load    = 1'b0;
      retire     = 1'b0;
      case (state)
         IDLE: begin
            if (run && go) state_next = FETCH;
         end
         FETCH: begin
            if (mem.mem_ack) begin
               ir_load    = 1'b1;
               state_next = LOAD_IR;
            end else if (expire) begin
               state_next = ERR;
            end
         end
         LOAD_IR: state_next = DECODE;
         DECODE: begin
            if (!stall) begin
               if (is_halt(ir)) begin
                  retire     = 1'b1;
                  state_next = HALT;
               end else begin
                  state_next = RD_A;
               end
            end
         end
         RD_A: begin
            if (!stall) state_next = RD_B;
         end
         RD_B: begin
            if (!stall) begin
               if (ir[IR_COMPUTE_BIT]) begin
                  state_next = EXEC;
               end else begin
                  retire     = 1'b1;
                  state_next = retire_to;
               end
            end
         end
         EXEC: begin
            if (!stall) begin
               retire     = 1'b1;
               state_next = retire_to;
            end
         end
         HALT: begin
            if (!run) state_next = IDLE;
         end
         ERR:     state_next = ERR;
         default: state_next = IDLE;
      endcase
   end

   // Outputs come from registered state and IR; stall only masks the strobes
   always_comb begin
      seq          = SEQ_NONE;
      mem.mem_req  = 1'b0;
      pc_inc       = 1'b0;
      ora          = 1'b0;
      orb          = 1'b0;
      irb          = 1'b0;
      halted       = 1'b0;
      bus_err      = 1'b0;
      case (state)
         FETCH: begin
            seq         = SEQ_0;
            mem.mem_req = 1'b1;
         end
         LOAD_IR: begin
            seq    = SEQ_1;
            pc_inc = 1'b1;
         end
         DECODE: seq = SEQ_2;
         RD_A: begin
            seq = SEQ_3;
            ora = !stall;
         end
         RD_B: begin
            seq = SEQ_4;
            orb = !stall && ir[IR_COMPUTE_BIT];
            irb = !stall && !ir[IR_COMPUTE_BIT];
         end
         EXEC: begin
            seq = SEQ_5;
            irb = !stall;
         end
         HALT:    halted  = 1'b1;
         ERR:     bus_err = 1'b1;
         default: seq     = SEQ_NONE;
      endcase
   end

endmodule
